// File: rtl/smc_pkg.sv
// smc_pkg
// Shared definitions for the SMC frame scoring engine:
//   - smc_state_e    : frame controller states (IDLE, LOAD, SUM, DONE)
//   - MODE_*_BIT     : bit positions inside the 2-bit in_mode word
//   - WEIGHT_BASE    : weight applied to the first selected value in ID mode
//   - smc_out_width  : result width that can never overflow for a given
//                      per-sample value width and selection count
package smc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SUM,
    DONE
  } smc_state_e;

  localparam int MODE_ID_BIT    = 0;
  localparam int MODE_LARGE_BIT = 1;
  localparam int WEIGHT_BASE    = 3;

  // Worst-case weight sum is 3+4+...+(K+2) = K*(K+5)/2, so the result
  // needs that many extra bits on top of one sample value.
  function automatic int smc_out_width(input int val_w, input int k_sel);
    return val_w + $clog2(k_sel * (k_sel + 5) / 2 + 1);
  endfunction

endpackage

// File: rtl/smc_mos_calc.sv
// smc_mos_calc
// Combinational per-sample transistor model. Produces either the drain
// current (ID) or the transconductance (gm) of one sample, divided by 3
// with the full-precision product formed before the divide.
// Ports:
//   w       in  IN_W   transistor width
//   vgs     in  IN_W   gate-source voltage
//   vds     in  IN_W   drain-source voltage
//   mode_id in  1      1 = ID, 0 = gm
//   value   out VAL_W  floor(result / 3)
module smc_mos_calc #(
  parameter int IN_W  = 3,
  parameter int VAL_W = 3 * IN_W + 1
) (
  input  logic [IN_W-1:0]  w,
  input  logic [IN_W-1:0]  vgs,
  input  logic [IN_W-1:0]  vds,
  input  logic             mode_id,
  output logic [VAL_W-1:0] value
);

  // Two spare bits over W*ov*vds cover the factor of 2 in the triode term.
  localparam int CW = 3 * IN_W + 2;

  logic [CW-1:0] w_e;
  logic [CW-1:0] ov_e;
  logic [CW-1:0] vds_e;
  logic [CW-1:0] num;

  // Region select: cutoff when vgs<=1, triode when the overdrive exceeds
  // vds, saturation otherwise. ov_e wraps in cutoff but is unused there.
  always_comb begin
    w_e   = CW'(w);
    vds_e = CW'(vds);
    ov_e  = CW'(vgs) - CW'(1);
    num   = '0;
    if (vgs > IN_W'(1)) begin
      if (ov_e > vds_e) begin
        num = mode_id ? w_e * ((CW'(2) * ov_e * vds_e) - (vds_e * vds_e))
                      : CW'(2) * w_e * vds_e;
      end else begin
        num = mode_id ? w_e * ov_e * ov_e
                      : CW'(2) * w_e * ov_e;
      end
    end
    value = VAL_W'(num / CW'(3));
  end

endmodule

// File: rtl/smc_stream_calc.sv
// smc_stream_calc
// Frame-level scoring engine. Accepts N_CH transistor samples over a
// valid/ready handshake, keeps their ID/gm values in a descending sorted
// register array (insertion sort, one value per cycle), then spends K_SEL
// cycles accumulating a weighted sum of the K_SEL largest or smallest values
// and presents it on a valid/ready output.
// Ports:
//   clk        in  1      rising-edge clock
//   rst        in  1      synchronous active-high reset
//   in_valid   in  1      sample valid
//   in_ready   out 1      sample accepted this cycle when in_valid is high
//   in_w       in  IN_W   transistor width
//   in_vgs     in  IN_W   gate-source voltage
//   in_vds     in  IN_W   drain-source voltage
//   in_mode    in  2      [0] 1=ID/0=gm, [1] 1=largest/0=smallest;
//                         only the first sample of a frame is looked at
//   out_valid  out 1      result valid
//   out_ready  in  1      consumer accepts result
//   out_n      out OUT_W  weighted sum
module smc_stream_calc
  import smc_pkg::*;
#(
  parameter  int N_CH  = 6,
  parameter  int K_SEL = 3,
  parameter  int IN_W  = 3,
  localparam int VAL_W = 3 * IN_W + 1,
  localparam int OUT_W = smc_out_width(VAL_W, K_SEL)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_w,
  input  logic [IN_W-1:0]  in_vgs,
  input  logic [IN_W-1:0]  in_vds,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_n
);

  if (N_CH < 2 || N_CH > 32) begin : g_bad_n_ch
    $error("smc_stream_calc: N_CH must be in 2..32");
  end
  if (K_SEL < 1 || K_SEL > N_CH) begin : g_bad_k_sel
    $error("smc_stream_calc: K_SEL must be in 1..N_CH");
  end

  localparam int CNT_W = $clog2(N_CH + 1);
  localparam int POS_W = $clog2(N_CH);
  localparam int IDX_W = $clog2(K_SEL + 1);

  smc_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       mode_q, mode_d;
  logic [VAL_W-1:0] val_q [N_CH];
  logic [VAL_W-1:0] val_d [N_CH];
  logic [OUT_W-1:0] acc_q, acc_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic             calc_id;
  logic [VAL_W-1:0] new_val;
  logic [N_CH-1:0]  ge;
  logic [POS_W-1:0] sel_pos;
  logic [VAL_W-1:0] sel_val;
  logic [OUT_W-1:0] weight;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_n     = acc_q;

  // The mode is not latched yet on the first sample, so take it straight
  // from the input in IDLE.
  assign accept  = in_valid && in_ready_q;
  assign calc_id = (state_q == IDLE) ? in_mode[MODE_ID_BIT] : mode_q[MODE_ID_BIT];

  smc_mos_calc #(
    .IN_W  (IN_W),
    .VAL_W (VAL_W)
  ) u_mos_calc (
    .w       (in_w),
    .vgs     (in_vgs),
    .vds     (in_vds),
    .mode_id (calc_id),
    .value   (new_val)
  );

  // ge[j] marks occupied slots that stay above the new value. Using >=
  // places a new equal value after the older ones, keeping arrival order.
  // Because the array is sorted, ge is a run of ones from index 0.
  always_comb begin
    for (int j = 0; j < N_CH; j++) begin
      ge[j] = (CNT_W'(j) < count_q) && (val_q[j] >= new_val);
    end
  end

  // Summation operand: a window of K_SEL slots starting at the top of the
  // array (largest) or ending at its bottom (smallest).
  always_comb begin
    sel_pos = mode_q[MODE_LARGE_BIT] ? POS_W'(0) : POS_W'(N_CH - K_SEL);
    sel_pos = sel_pos + POS_W'(idx_q);
    sel_val = val_q[sel_pos];
    weight  = mode_q[MODE_ID_BIT] ? OUT_W'(WEIGHT_BASE) + OUT_W'(idx_q) : OUT_W'(1);
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    idx_d       = idx_q;
    mode_d      = mode_q;
    val_d       = val_q;
    acc_d       = acc_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE, LOAD: begin
        if (accept) begin
          // Insert: slots above the insertion point keep their value, the
          // insertion point takes the new value, the rest shift down by one.
          val_d[0] = ge[0] ? val_q[0] : new_val;
          for (int j = 1; j < N_CH; j++) begin
            if (ge[j]) begin
              val_d[j] = val_q[j];
            end else if (ge[j-1]) begin
              val_d[j] = new_val;
            end else begin
              val_d[j] = val_q[j-1];
            end
          end
          count_d = count_q + CNT_W'(1);
          if (state_q == IDLE) begin
            mode_d = in_mode;
          end
          if (count_d == CNT_W'(N_CH)) begin
            state_d    = SUM;
            in_ready_d = 1'b0;
            idx_d      = '0;
            acc_d      = '0;
          end else begin
            state_d = LOAD;
          end
        end
      end
      SUM: begin
        acc_d = acc_q + OUT_W'(sel_val) * weight;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(K_SEL - 1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_valid_q && out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          count_d     = '0;
          acc_d       = '0;
          for (int j = 0; j < N_CH; j++) begin
            val_d[j] = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Single state register for the frame controller and its outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      idx_q       <= '0;
      mode_q      <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      for (int j = 0; j < N_CH; j++) begin
        val_q[j] <= '0;
      end
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      mode_q      <= mode_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      val_q       <= val_d;
    end
  end

endmodule

// File: tb/tb_smc_stream_calc.sv
// tb_smc_stream_calc
// Self-checking bench for smc_stream_calc with default parameters. Frames are
// scored by a behavioural model (device equations, sort, weighted sum) and
// compared against the DUT result, latency and handshake behaviour.
module tb_smc_stream_calc;

  localparam int N_CH  = 6;
  localparam int K_SEL = 3;
  localparam int IN_W  = 3;
  localparam int VAL_W = 3 * IN_W + 1;
  localparam int OUT_W = VAL_W + $clog2(K_SEL * (K_SEL + 5) / 2 + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in_w = '0;
  logic [IN_W-1:0]  in_vgs = '0;
  logic [IN_W-1:0]  in_vds = '0;
  logic [1:0]       in_mode = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [OUT_W-1:0] out_n;

  int compare_count  = 0;
  int mismatch_count = 0;

  int fw [N_CH];
  int fg [N_CH];
  int fd [N_CH];

  smc_stream_calc #(
    .N_CH  (N_CH),
    .K_SEL (K_SEL),
    .IN_W  (IN_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_w      (in_w),
    .in_vgs    (in_vgs),
    .in_vds    (in_vds),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_n     (out_n)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compare_count++;
    if (observed != expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int modelValue(input int w, input int vgs, input int vds, input bit id_mode);
    int ov;
    ov = vgs - 1;
    if (vgs <= 1) return 0;
    if (ov > vds) return id_mode ? (w * (2 * ov * vds - vds * vds)) / 3 : (2 * w * vds) / 3;
    return id_mode ? (w * ov * ov) / 3 : (2 * w * ov) / 3;
  endfunction

  function automatic int modelFrame(input logic [1:0] mode);
    int vals [N_CH];
    int tmp;
    int base;
    int sum;
    for (int s = 0; s < N_CH; s++) vals[s] = modelValue(fw[s], fg[s], fd[s], mode[0]);
    for (int a = 0; a < N_CH; a++) begin
      for (int b = 0; b < N_CH - 1 - a; b++) begin
        if (vals[b] < vals[b+1]) begin
          tmp       = vals[b];
          vals[b]   = vals[b+1];
          vals[b+1] = tmp;
        end
      end
    end
    base = mode[1] ? 0 : N_CH - K_SEL;
    sum  = 0;
    for (int i = 0; i < K_SEL; i++) sum += vals[base + i] * (mode[0] ? 3 + i : 1);
    return sum;
  endfunction

  task automatic setFrame(input int w0, input int w1, input int w2, input int w3,
                          input int w4, input int w5, input int vgs, input int vds);
    fw[0] = w0; fw[1] = w1; fw[2] = w2; fw[3] = w3; fw[4] = w4; fw[5] = w5;
    for (int s = 0; s < N_CH; s++) begin
      fg[s] = vgs;
      fd[s] = vds;
    end
  endtask

  // Present the frame held in fw/fg/fd, with random idle gaps and random
  // noise on in_mode for every sample after the first.
  task automatic sendFrame(input logic [1:0] mode, input int gap_max);
    int gaps;
    for (int s = 0; s < N_CH; s++) begin
      gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (gaps) begin
        in_valid = 1'b0;
        in_w     = IN_W'($urandom);
        in_vgs   = IN_W'($urandom);
        in_vds   = IN_W'($urandom);
        in_mode  = 2'($urandom);
        step();
      end
      in_valid = 1'b1;
      in_w     = IN_W'(fw[s]);
      in_vgs   = IN_W'(fg[s]);
      in_vds   = IN_W'(fd[s]);
      in_mode  = (s == 0) ? mode : 2'($urandom);
      step();
    end
    in_valid = 1'b0;
  endtask

  // Full frame: send, check latency and result, stall the output for
  // hold_cycles while poking in_valid, then complete the output handshake.
  task automatic applyStimulus(input string tag, input logic [1:0] mode,
                               input int gap_max, input int hold_cycles);
    int expected;
    int cyc;
    expected = modelFrame(mode);
    sendFrame(mode, gap_max);
    cyc = 1;
    while (!out_valid && cyc <= K_SEL + 10) begin
      checkOutput({tag, "_busy_ready"}, int'(in_ready), 0);
      step();
      cyc++;
    end
    checkOutput({tag, "_latency"}, cyc, K_SEL + 1);
    checkOutput({tag, "_out_n"}, int'(out_n), expected);
    for (int h = 0; h < hold_cycles; h++) begin
      out_ready = 1'b0;
      in_valid  = 1'($urandom);
      in_w      = IN_W'($urandom);
      in_vgs    = IN_W'($urandom);
      in_vds    = IN_W'($urandom);
      step();
      checkOutput({tag, "_hold_valid"}, int'(out_valid), 1);
      checkOutput({tag, "_hold_n"}, int'(out_n), expected);
      checkOutput({tag, "_hold_ready"}, int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checkOutput({tag, "_post_ready"}, int'(in_ready), 1);
    checkOutput({tag, "_post_valid"}, int'(out_valid), 0);
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    checkOutput("reset_in_ready", int'(in_ready), 1);
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_out_n", int'(out_n), 0);
    rst = 1'b0;
    step();

    setFrame(1, 2, 3, 4, 5, 6, 7, 7);
    applyStimulus("large_id", 2'b11, 0, 0);
    checkOutput("large_id_model", modelFrame(2'b11), 696);
    applyStimulus("small_id", 2'b01, 0, 0);
    checkOutput("small_id_model", modelFrame(2'b01), 264);

    setFrame(7, 7, 7, 7, 7, 7, 7, 7);
    applyStimulus("gm_large", 2'b10, 1, 0);
    setFrame(7, 7, 7, 7, 7, 7, 1, 7);
    applyStimulus("cutoff", 2'b10, 1, 0);

    setFrame(3, 0, 0, 0, 0, 0, 1, 0);
    fg[0] = 5;
    fd[0] = 2;
    applyStimulus("triode_id", 2'b11, 2, 0);
    checkOutput("triode_id_model", modelFrame(2'b11), 36);
    applyStimulus("triode_gm", 2'b10, 2, 0);
    checkOutput("triode_gm_model", modelFrame(2'b10), 4);

    setFrame(1, 2, 3, 4, 5, 6, 7, 7);
    applyStimulus("hold", 2'b11, 0, 5);

    // Abort a partial frame with reset, then confirm no residue.
    setFrame(7, 7, 7, 7, 7, 7, 7, 7);
    for (int s = 0; s < 3; s++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(2, 0)) step();
      in_valid = 1'b1;
      in_w     = IN_W'(fw[s]);
      in_vgs   = IN_W'(fg[s]);
      in_vds   = IN_W'(fd[s]);
      in_mode  = 2'b11;
      step();
    end
    rst = 1'b1;
    step();
    in_valid = 1'b0;
    checkOutput("rst_load_ready", int'(in_ready), 1);
    checkOutput("rst_load_valid", int'(out_valid), 0);
    rst = 1'b0;
    setFrame(1, 2, 3, 4, 5, 6, 7, 7);
    applyStimulus("after_rst", 2'b11, 2, 0);

    // Reset while a result is pending drops it.
    sendFrame(2'b11, 0);
    repeat (K_SEL + 2) step();
    checkOutput("rst_done_pending", int'(out_valid), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("rst_done_valid", int'(out_valid), 0);
    checkOutput("rst_done_n", int'(out_n), 0);
    checkOutput("rst_done_ready", int'(in_ready), 1);

    // Random frames.
    for (int f = 0; f < 30; f++) begin
      for (int s = 0; s < N_CH; s++) begin
        fw[s] = int'($urandom_range(7, 0));
        fg[s] = int'($urandom_range(7, 0));
        fd[s] = int'($urandom_range(7, 0));
      end
      applyStimulus($sformatf("rand%0d", f), 2'($urandom), 2, int'($urandom_range(3, 0)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
